// File: rtl/lab2_proc_multi_drop_unit_pkg.sv
// rtl/lab2_proc_multi_drop_unit_pkg.sv - shared widths and helpers for the multi-drop response unit
package lab2_proc_multi_drop_unit_pkg;

  // Width of mem_resp_4B_t; used only as the default message width.
  localparam int unsigned MEM_RESP_4B_NBITS = 46;

  function automatic int unsigned count_width(input int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/lab2_proc_multi_drop_unit_counter.sv
// rtl/lab2_proc_multi_drop_unit_counter.sv - up/down counter with synchronous reset and load
module lab2_proc_UpDownCounter #(
  parameter int p_nbits = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               incr,
  input  logic               decr,
  input  logic               load,
  input  logic [p_nbits-1:0] load_data,
  output logic [p_nbits-1:0] count
);

  logic [p_nbits-1:0] count_q;
  logic [p_nbits-1:0] count_d;

  // Load has priority; a simultaneous increment and decrement cancel out.
  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_data;
    else if (incr && !decr)
      count_d = count_q + 1'b1;
    else if (decr && !incr)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/lab2_proc_multi_drop_unit.sv
// rtl/lab2_proc_multi_drop_unit.sv - discards responses owed to squashed requests, up to p_max_inflight outstanding
module lab2_proc_multi_drop_unit
  import lab2_proc_multi_drop_unit_pkg::*;
#(
  parameter int p_msg_nbits    = MEM_RESP_4B_NBITS,
  parameter int p_max_inflight = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_sent,
  input  logic                                  drop,
  input  logic [p_msg_nbits-1:0]                istream_msg,
  input  logic                                  istream_val,
  output logic                                  istream_rdy,
  output logic [p_msg_nbits-1:0]                ostream_msg,
  output logic                                  ostream_val,
  input  logic                                  ostream_rdy,
  output logic                                  req_rdy,
  output logic [$clog2(p_max_inflight+1)-1:0]   num_inflight,
  output logic [$clog2(p_max_inflight+1)-1:0]   num_drop_pending
);

  localparam int CW = count_width(p_max_inflight);

  logic          resp_xfer;
  logic          discarding;
  logic          pending_nz;
  logic [CW-1:0] pending_load_data;

  assign pending_nz  = (num_drop_pending != '0);
  assign discarding  = drop | pending_nz;
  assign resp_xfer   = istream_val & istream_rdy;

  assign ostream_msg = istream_msg;
  assign ostream_val = istream_val & ~discarding & ~reset;
  assign istream_rdy = ~reset & (discarding | ostream_rdy);
  assign req_rdy     = ~reset & (num_inflight < CW'(p_max_inflight));

  // A request sent in the drop cycle is the redirected fetch, so it is left out of the reload.
  assign pending_load_data = num_inflight - CW'(resp_xfer);

  lab2_proc_UpDownCounter #(.p_nbits(CW)) inflight_ctr (
    .clk       (clk),
    .reset     (reset),
    .incr      (req_sent),
    .decr      (resp_xfer),
    .load      (1'b0),
    .load_data ('0),
    .count     (num_inflight)
  );

  lab2_proc_UpDownCounter #(.p_nbits(CW)) drop_pending_ctr (
    .clk       (clk),
    .reset     (reset),
    .incr      (1'b0),
    .decr      (resp_xfer & pending_nz),
    .load      (drop),
    .load_data (pending_load_data),
    .count     (num_drop_pending)
  );

  a_no_req_overflow: assert property (@(posedge clk) disable iff (reset)
    !(req_sent && (num_inflight == CW'(p_max_inflight))))
    else $error("request sent with inflight count at maximum");

  a_no_resp_underflow: assert property (@(posedge clk) disable iff (reset)
    !(istream_val && (num_inflight == '0)))
    else $error("response valid with no request inflight");

endmodule

// File: tb/tb_lab2_proc_multi_drop_unit.sv
// tb/tb_lab2_proc_multi_drop_unit.sv - directed-vector bench for the multi-drop response unit
module tb_lab2_proc_multi_drop_unit;

  localparam int MW = 46;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: p_max_inflight = 2
  logic          a_reset, a_req_sent, a_drop, a_ival, a_irdy, a_oval, a_ordy, a_req_rdy;
  logic [MW-1:0] a_imsg, a_omsg;
  logic [1:0]    a_ninf, a_npend;

  // Instance B: p_max_inflight = 4
  logic          b_reset, b_req_sent, b_drop, b_ival, b_irdy, b_oval, b_ordy, b_req_rdy;
  logic [MW-1:0] b_imsg, b_omsg;
  logic [2:0]    b_ninf, b_npend;

  lab2_proc_multi_drop_unit #(.p_msg_nbits(MW), .p_max_inflight(2)) dut_a (
    .clk(clk), .reset(a_reset), .req_sent(a_req_sent), .drop(a_drop),
    .istream_msg(a_imsg), .istream_val(a_ival), .istream_rdy(a_irdy),
    .ostream_msg(a_omsg), .ostream_val(a_oval), .ostream_rdy(a_ordy),
    .req_rdy(a_req_rdy), .num_inflight(a_ninf), .num_drop_pending(a_npend)
  );

  lab2_proc_multi_drop_unit #(.p_msg_nbits(MW), .p_max_inflight(4)) dut_b (
    .clk(clk), .reset(b_reset), .req_sent(b_req_sent), .drop(b_drop),
    .istream_msg(b_imsg), .istream_val(b_ival), .istream_rdy(b_irdy),
    .ostream_msg(b_omsg), .ostream_val(b_oval), .ostream_rdy(b_ordy),
    .req_rdy(b_req_rdy), .num_inflight(b_ninf), .num_drop_pending(b_npend)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic rs, input logic rq, input logic dr,
                       input logic iv, input logic [MW-1:0] msg, input logic ordy);
    a_reset = rs; a_req_sent = rq; a_drop = dr; a_ival = iv; a_imsg = msg; a_ordy = ordy;
    #1;
  endtask

  task automatic set_b(input logic rs, input logic rq, input logic dr,
                       input logic iv, input logic [MW-1:0] msg, input logic ordy);
    b_reset = rs; b_req_sent = rq; b_drop = dr; b_ival = iv; b_imsg = msg; b_ordy = ordy;
    #1;
  endtask

  initial begin
    set_a(1, 0, 0, 1, '0, 1);
    set_b(1, 0, 0, 0, '0, 0);
    check("rst_oval", a_oval, 0);
    check("rst_irdy", a_irdy, 0);
    check("rst_req_rdy", a_req_rdy, 0);
    tick();
    tick();
    check("rst_inflight", a_ninf, 0);
    check("rst_pending", a_npend, 0);
    set_b(0, 0, 0, 0, '0, 0);

    // No drop: fill to max, then drain A then B
    set_a(0, 0, 0, 0, '0, 1);
    check("t1_req_rdy0", a_req_rdy, 1);
    set_a(0, 1, 0, 0, '0, 1); tick();
    check("t1_inf1", a_ninf, 1);
    check("t1_req_rdy1", a_req_rdy, 1);
    set_a(0, 1, 0, 0, '0, 1); tick();
    check("t1_inf2", a_ninf, 2);
    check("t1_req_rdy_full", a_req_rdy, 0);
    set_a(0, 0, 0, 1, 46'hA, 1);
    check("t1_oval_a", a_oval, 1);
    check("t1_omsg_a", a_omsg, 46'hA);
    check("t1_irdy_a", a_irdy, 1);
    tick();
    check("t1_inf_after_a", a_ninf, 1);
    set_a(0, 0, 0, 1, 46'hB, 1);
    check("t1_oval_b", a_oval, 1);
    check("t1_omsg_b", a_omsg, 46'hB);
    tick();
    check("t1_inf_end", a_ninf, 0);
    set_a(0, 0, 0, 0, '0, 1);
    check("t1_req_rdy_end", a_req_rdy, 1);

    // Drop coincident with a response under backpressure
    set_a(0, 1, 0, 0, '0, 0); tick();
    set_a(0, 1, 0, 0, '0, 0); tick();
    set_a(0, 0, 1, 1, 46'hA, 0);
    check("t3_irdy", a_irdy, 1);
    check("t3_oval", a_oval, 0);
    tick();
    check("t3_pend1", a_npend, 1);
    check("t3_inf1", a_ninf, 1);
    set_a(0, 0, 0, 1, 46'hB, 0);
    check("t3_irdy_b", a_irdy, 1);
    check("t3_oval_b", a_oval, 0);
    tick();
    check("t3_pend0", a_npend, 0);
    check("t3_inf0", a_ninf, 0);

    // Backpressure with nothing pending
    set_a(0, 1, 0, 0, '0, 0); tick();
    set_a(0, 0, 0, 1, 46'h77, 0);
    check("t5_irdy", a_irdy, 0);
    check("t5_oval", a_oval, 1);
    tick();
    check("t5_inf_hold", a_ninf, 1);
    set_a(0, 0, 0, 1, 46'h77, 1);
    check("t5_irdy_up", a_irdy, 1);
    tick();
    check("t5_inf0", a_ninf, 0);

    // Reset mid-drop
    set_a(0, 1, 0, 0, '0, 1); tick();
    set_a(0, 1, 0, 0, '0, 1); tick();
    set_a(0, 0, 1, 0, '0, 1); tick();
    check("t6_pend2", a_npend, 2);
    set_a(1, 0, 0, 1, 46'h5, 1);
    check("t6_oval_rst", a_oval, 0);
    check("t6_irdy_rst", a_irdy, 0);
    check("t6_req_rdy_rst", a_req_rdy, 0);
    tick();
    check("t6_inf_rst", a_ninf, 0);
    check("t6_pend_rst", a_npend, 0);
    set_a(0, 1, 0, 0, '0, 1); tick();
    set_a(0, 0, 0, 1, 46'h5, 1);
    check("t6_oval_post", a_oval, 1);
    check("t6_omsg_post", a_omsg, 46'h5);
    tick();
    check("t6_inf_post", a_ninf, 0);
    set_a(0, 0, 0, 0, '0, 1);

    // Squash two outstanding, redirected fetch sent in the drop cycle
    set_b(0, 1, 0, 0, '0, 0); tick();
    set_b(0, 1, 0, 0, '0, 0); tick();
    set_b(0, 1, 1, 0, '0, 0);
    check("t2_irdy_drop", b_irdy, 1);
    tick();
    check("t2_pend2", b_npend, 2);
    check("t2_inf3", b_ninf, 3);
    set_b(0, 0, 0, 1, 46'hA, 0);
    check("t2_oval_a", b_oval, 0);
    check("t2_irdy_a", b_irdy, 1);
    tick();
    check("t2_pend1", b_npend, 1);
    set_b(0, 0, 0, 1, 46'hB, 0);
    check("t2_oval_b", b_oval, 0);
    tick();
    check("t2_pend0", b_npend, 0);
    check("t2_inf1", b_ninf, 1);
    set_b(0, 0, 0, 1, 46'hC, 1);
    check("t2_oval_c", b_oval, 1);
    check("t2_omsg_c", b_omsg, 46'hC);
    tick();
    check("t2_inf0", b_ninf, 0);

    // Re-drop while pending
    for (int i = 0; i < 3; i++) begin
      set_b(0, 1, 0, 0, '0, 1); tick();
    end
    check("t4_inf3", b_ninf, 3);
    set_b(0, 0, 1, 0, '0, 1); tick();
    check("t4_pend3", b_npend, 3);
    set_b(0, 1, 0, 1, 46'h11, 1);
    check("t4_oval_d1", b_oval, 0);
    tick();
    check("t4_pend2", b_npend, 2);
    check("t4_inf3b", b_ninf, 3);
    set_b(0, 0, 1, 0, '0, 1); tick();
    check("t4_pend3b", b_npend, 3);
    for (int i = 0; i < 3; i++) begin
      set_b(0, 0, 0, 1, 46'h20 + 46'(i), 1);
      check("t4_oval_drain", b_oval, 0);
      check("t4_irdy_drain", b_irdy, 1);
      tick();
    end
    check("t4_pend_end", b_npend, 0);
    check("t4_inf_end", b_ninf, 0);
    set_b(0, 0, 0, 0, '0, 1);
    check("t4_req_rdy_end", b_req_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
